// File: rtl/imem_shift_array_if.sv
// rtl/imem_shift_array_if.sv - insert channel (valid/ready word plus shift direction) for imem_shift_array
interface imem_shift_array_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             dir;

  modport master (
    output in_valid,
    output in_data,
    output dir,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  dir,
    output in_ready
  );
endinterface

// File: rtl/imem_shift_array.sv
// rtl/imem_shift_array.sv - bidirectional shift-register word array with insert handshake and registered read
// Optional random write port (wr_en/wr_addr/wr_data) is built when IMEM_SHIFT_ARRAY_RAND_WR_EN is defined.
module imem_shift_array #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 64,
  parameter  int MODE  = 0,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  imem_shift_array_if.slave      ins,
  input  logic [AW-1:0]          rd_addr,
  output logic [WIDTH-1:0]       rd_data,
  output logic [CW-1:0]          count,
  output logic                   full,
  output logic                   empty,
  output logic [WIDTH*DEPTH-1:0] data_out
`ifdef IMEM_SHIFT_ARRAY_RAND_WR_EN
  ,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [WIDTH-1:0]       wr_data
`endif
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [WIDTH-1:0] rd_data_q;
  logic [WIDTH-1:0] rd_data_d;
  logic             accept;

  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign count        = count_q;
  assign rd_data      = rd_data_q;
  // Fill-stop mode refuses inserts once saturated; free-running always accepts.
  assign ins.in_ready = !rst && ((MODE == 1) ? !full : 1'b1);
  assign accept       = ins.in_valid && ins.in_ready && !clr;

  always_comb begin
    data_out = '0;
    for (int j = 0; j < DEPTH; j++) begin
      data_out[j*WIDTH +: WIDTH] = mem_q[j];
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    count_d   = count_q;
    rd_data_d = '0;
    // Read samples the pre-edge contents, so a same-edge shift is not visible.
    if (32'(rd_addr) < DEPTH) begin
      rd_data_d = mem_q[rd_addr];
    end
    if (accept) begin
      if (!ins.dir) begin
        for (int i = DEPTH - 1; i > 0; i--) begin
          mem_d[i] = mem_q[i-1];
        end
        mem_d[0] = ins.in_data;
      end else begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          mem_d[i] = mem_q[i+1];
        end
        mem_d[DEPTH-1] = ins.in_data;
      end
      if (!full) begin
        count_d = count_q + CW'(1);
      end
    end
`ifdef IMEM_SHIFT_ARRAY_RAND_WR_EN
    // Applied after the shift so the write lands at the post-shift index.
    if (wr_en && (32'(wr_addr) < DEPTH)) begin
      mem_d[wr_addr] = wr_data;
    end
`endif
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] = '0;
      end
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

endmodule

// File: tb/tb_imem_shift_array.sv
// tb/tb_imem_shift_array.sv - directed self-checking bench for imem_shift_array (three configurations)
module tb_imem_shift_array;

  logic clk;
  logic rst;

  // u0: defaults (WIDTH 16, DEPTH 64, MODE 0)
  logic            u0_clr;
  logic [5:0]      u0_rd_addr;
  logic [15:0]     u0_rd_data;
  logic [6:0]      u0_count;
  logic            u0_full;
  logic            u0_empty;
  logic [1023:0]   u0_dout;

  // u1: DEPTH 4, MODE 1 (fill-stop)
  logic            u1_clr;
  logic [1:0]      u1_rd_addr;
  logic [15:0]     u1_rd_data;
  logic [2:0]      u1_count;
  logic            u1_full;
  logic            u1_empty;
  logic [63:0]     u1_dout;

  // u2: DEPTH 4, MODE 0
  logic            u2_clr;
  logic [1:0]      u2_rd_addr;
  logic [15:0]     u2_rd_data;
  logic [2:0]      u2_count;
  logic            u2_full;
  logic            u2_empty;
  logic [63:0]     u2_dout;
`ifdef IMEM_SHIFT_ARRAY_RAND_WR_EN
  logic            u2_wr_en;
  logic [1:0]      u2_wr_addr;
  logic [15:0]     u2_wr_data;
`endif

  int n_checks;
  int n_fail;

  imem_shift_array_if #(.WIDTH(16)) if0 ();
  imem_shift_array_if #(.WIDTH(16)) if1 ();
  imem_shift_array_if #(.WIDTH(16)) if2 ();

  imem_shift_array #(.WIDTH(16), .DEPTH(64), .MODE(0)) u0 (
    .clk(clk), .rst(rst), .clr(u0_clr), .ins(if0.slave),
    .rd_addr(u0_rd_addr), .rd_data(u0_rd_data), .count(u0_count),
    .full(u0_full), .empty(u0_empty), .data_out(u0_dout)
`ifdef IMEM_SHIFT_ARRAY_RAND_WR_EN
    , .wr_en(1'b0), .wr_addr(6'd0), .wr_data(16'd0)
`endif
  );

  imem_shift_array #(.WIDTH(16), .DEPTH(4), .MODE(1)) u1 (
    .clk(clk), .rst(rst), .clr(u1_clr), .ins(if1.slave),
    .rd_addr(u1_rd_addr), .rd_data(u1_rd_data), .count(u1_count),
    .full(u1_full), .empty(u1_empty), .data_out(u1_dout)
`ifdef IMEM_SHIFT_ARRAY_RAND_WR_EN
    , .wr_en(1'b0), .wr_addr(2'd0), .wr_data(16'd0)
`endif
  );

  imem_shift_array #(.WIDTH(16), .DEPTH(4), .MODE(0)) u2 (
    .clk(clk), .rst(rst), .clr(u2_clr), .ins(if2.slave),
    .rd_addr(u2_rd_addr), .rd_data(u2_rd_data), .count(u2_count),
    .full(u2_full), .empty(u2_empty), .data_out(u2_dout)
`ifdef IMEM_SHIFT_ARRAY_RAND_WR_EN
    , .wr_en(u2_wr_en), .wr_addr(u2_wr_addr), .wr_data(u2_wr_data)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    u0_clr = 1'b0; u0_rd_addr = '0; if0.in_valid = 1'b0; if0.in_data = '0; if0.dir = 1'b0;
    u1_clr = 1'b0; u1_rd_addr = '0; if1.in_valid = 1'b0; if1.in_data = '0; if1.dir = 1'b0;
    u2_clr = 1'b0; u2_rd_addr = '0; if2.in_valid = 1'b0; if2.in_data = '0; if2.dir = 1'b0;
`ifdef IMEM_SHIFT_ARRAY_RAND_WR_EN
    u2_wr_en = 1'b0; u2_wr_addr = '0; u2_wr_data = '0;
`endif

    // Reset state
    #12;
    chk("rst_count", 64'(u0_count), 64'd0);
    chk("rst_empty", 64'(u0_empty), 64'd1);
    chk("rst_full", 64'(u0_full), 64'd0);
    chk("rst_ready", 64'(if0.in_ready), 64'd0);
    chk("rst_rd_data", 64'(u0_rd_data), 64'd0);
    rst = 1'b0;
    #1;
    chk("rel_ready", 64'(if0.in_ready), 64'd1);

    // Free-running: 70 back-to-back inserts at word 0
    for (int i = 1; i <= 70; i++) begin
      if0.in_valid = 1'b1;
      if0.in_data  = 16'(i);
      chk($sformatf("fr_ready_%0d", i), 64'(if0.in_ready), 64'd1);
      tick();
    end
    if0.in_valid = 1'b0;
    chk("fr_w0", 64'(u0_dout[0*16 +: 16]), 64'h0046);
    chk("fr_w63", 64'(u0_dout[63*16 +: 16]), 64'h0007);
    chk("fr_count", 64'(u0_count), 64'd64);
    chk("fr_full", 64'(u0_full), 64'd1);
    chk("fr_empty", 64'(u0_empty), 64'd0);
    u0_rd_addr = 6'd5;
    tick();
    chk("fr_rd5", 64'(u0_rd_data), 64'h0041);
    chk("idle_w0", 64'(u0_dout[0*16 +: 16]), 64'h0046);
    chk("idle_count", 64'(u0_count), 64'd64);

    // clr overrides a concurrent accept
    u0_clr = 1'b1; if0.in_valid = 1'b1; if0.in_data = 16'h0099;
    tick();
    u0_clr = 1'b0; if0.in_valid = 1'b0;
    chk("clr_w0", 64'(u0_dout[0*16 +: 16]), 64'd0);
    chk("clr_w63", 64'(u0_dout[63*16 +: 16]), 64'd0);
    chk("clr_count", 64'(u0_count), 64'd0);
    chk("clr_empty", 64'(u0_empty), 64'd1);

    // 10 inserts, then clr with in_valid
    u0_rd_addr = 6'd0;
    for (int i = 1; i <= 10; i++) begin
      if0.in_valid = 1'b1;
      if0.in_data  = 16'(16'h0100 + i);
      tick();
    end
    chk("ten_count", 64'(u0_count), 64'd10);
    chk("ten_w0", 64'(u0_dout[0*16 +: 16]), 64'h010A);
    chk("ten_w9", 64'(u0_dout[9*16 +: 16]), 64'h0101);
    chk("ten_rd0", 64'(u0_rd_data), 64'h0109);
    u0_clr = 1'b1; if0.in_data = 16'h0777;
    tick();
    u0_clr = 1'b0; if0.in_valid = 1'b0;
    chk("clr10_w0", 64'(u0_dout[0*16 +: 16]), 64'd0);
    chk("clr10_w9", 64'(u0_dout[9*16 +: 16]), 64'd0);
    chk("clr10_count", 64'(u0_count), 64'd0);
    chk("clr10_empty", 64'(u0_empty), 64'd1);

    // Refill a few words, then pulse rst between edges
    for (int i = 1; i <= 3; i++) begin
      if0.in_valid = 1'b1;
      if0.in_data  = 16'(16'h0200 + i);
      tick();
    end
    chk("pre_rst_rd0", 64'(u0_rd_data), 64'h0202);
    rst = 1'b1;
    #2;
    chk("arst_count", 64'(u0_count), 64'd0);
    chk("arst_w0", 64'(u0_dout[0*16 +: 16]), 64'd0);
    chk("arst_rd", 64'(u0_rd_data), 64'd0);
    chk("arst_ready", 64'(if0.in_ready), 64'd0);
    chk("arst_empty", 64'(u0_empty), 64'd1);
    rst = 1'b0;
    if0.in_data = 16'h0055;
    #1;
    tick();
    if0.in_valid = 1'b0;
    chk("post_rst_w0", 64'(u0_dout[0*16 +: 16]), 64'h0055);
    chk("post_rst_w1", 64'(u0_dout[1*16 +: 16]), 64'd0);
    chk("post_rst_count", 64'(u0_count), 64'd1);

    // Fill-stop: A..D accepted, E refused
    for (int i = 0; i < 4; i++) begin
      if1.in_valid = 1'b1;
      if1.in_data  = 16'(16'h000A + i);
      chk($sformatf("fs_ready_%0d", i), 64'(if1.in_ready), 64'd1);
      tick();
    end
    if1.in_data = 16'h000E;
    chk("fs_ready_E", 64'(if1.in_ready), 64'd0);
    chk("fs_full", 64'(u1_full), 64'd1);
    tick();
    if1.in_valid = 1'b0;
    chk("fs_w0", 64'(u1_dout[0*16 +: 16]), 64'h000D);
    chk("fs_w1", 64'(u1_dout[1*16 +: 16]), 64'h000C);
    chk("fs_w2", 64'(u1_dout[2*16 +: 16]), 64'h000B);
    chk("fs_w3", 64'(u1_dout[3*16 +: 16]), 64'h000A);
    chk("fs_count", 64'(u1_count), 64'd4);
    u1_clr = 1'b1;
    tick();
    u1_clr = 1'b0;
    chk("fs_clr_ready", 64'(if1.in_ready), 64'd1);
    chk("fs_clr_full", 64'(u1_full), 64'd0);

    // dir=1: insert at word 3, shift toward 0
    if2.dir = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      if2.in_valid = 1'b1;
      if2.in_data  = 16'(i);
      tick();
    end
    if2.in_valid = 1'b0;
    chk("d1_w3", 64'(u2_dout[3*16 +: 16]), 64'd3);
    chk("d1_w2", 64'(u2_dout[2*16 +: 16]), 64'd2);
    chk("d1_w1", 64'(u2_dout[1*16 +: 16]), 64'd1);
    chk("d1_w0", 64'(u2_dout[0*16 +: 16]), 64'd0);
    chk("d1_count", 64'(u2_count), 64'd3);
    u2_rd_addr = 2'd2;
    tick();
    chk("d1_rd2", 64'(u2_rd_data), 64'd2);

    // dir flips per accept; read sees pre-edge word
    u2_rd_addr = 2'd3;
    if2.in_valid = 1'b1; if2.in_data = 16'd4; if2.dir = 1'b0;
    tick();
    chk("flip0_rd3_old", 64'(u2_rd_data), 64'd3);
    chk("flip0_w0", 64'(u2_dout[0*16 +: 16]), 64'd4);
    chk("flip0_w3", 64'(u2_dout[3*16 +: 16]), 64'd2);
    chk("flip0_full", 64'(u2_full), 64'd1);
    if2.in_data = 16'd5; if2.dir = 1'b1;
    tick();
    if2.in_valid = 1'b0;
    chk("flip1_w3", 64'(u2_dout[3*16 +: 16]), 64'd5);
    chk("flip1_w0", 64'(u2_dout[0*16 +: 16]), 64'd0);
    chk("flip1_w2", 64'(u2_dout[2*16 +: 16]), 64'd2);
    chk("flip1_count", 64'(u2_count), 64'd4);

`ifdef IMEM_SHIFT_ARRAY_RAND_WR_EN
    // Contents 4,3,2,1 then accept 5 with a random write to post-shift word 1
    u2_clr = 1'b1;
    tick();
    u2_clr = 1'b0;
    if2.dir = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if2.in_valid = 1'b1;
      if2.in_data  = 16'(i);
      tick();
    end
    if2.in_data = 16'd5;
    u2_wr_en = 1'b1; u2_wr_addr = 2'd1; u2_wr_data = 16'hBEEF;
    tick();
    if2.in_valid = 1'b0;
    chk("rw_w0", 64'(u2_dout[0*16 +: 16]), 64'd5);
    chk("rw_w1", 64'(u2_dout[1*16 +: 16]), 64'hBEEF);
    chk("rw_w2", 64'(u2_dout[2*16 +: 16]), 64'd3);
    chk("rw_w3", 64'(u2_dout[3*16 +: 16]), 64'd2);
    chk("rw_count", 64'(u2_count), 64'd4);
    u2_wr_addr = 2'd0; u2_wr_data = 16'h1234;
    tick();
    chk("rw_only_w0", 64'(u2_dout[0*16 +: 16]), 64'h1234);
    chk("rw_only_w1", 64'(u2_dout[1*16 +: 16]), 64'hBEEF);
    u2_clr = 1'b1; u2_wr_addr = 2'd2;
    tick();
    u2_clr = 1'b0; u2_wr_en = 1'b0;
    chk("rw_clr_w2", 64'(u2_dout[2*16 +: 16]), 64'd0);
    chk("rw_clr_count", 64'(u2_count), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_shift_array.md
IMEM_SHIFT_ARRAY -- requirements
Module: imem_shift_array

Interface
REQ-001 Parameter WIDTH, 16, bits per word.
REQ-002 Parameter DEPTH, 64, number of words; SHALL be >= 2.
REQ-003 Parameter MODE, 0, 0 = free-running (oldest word discarded), 1 = fill-stop (insert refused when full).
REQ-004 Derived AW = clog2(DEPTH); CW = clog2(DEPTH+1).
REQ-005 clk  in  1  clock, all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 clr  in  1  synchronous clear of contents and count.
REQ-008 in_valid  in  1  insert request.
REQ-009 in_ready  out  1  insert accepted when in_valid && in_ready.
REQ-010 in_data  in  WIDTH  word to insert.
REQ-011 dir  in  1  0: insert at word 0, words shift toward DEPTH-1; 1: insert at word DEPTH-1, words shift toward 0.
REQ-012 rd_addr  in  AW  random read address.
REQ-013 rd_data  out  WIDTH  registered read data.
REQ-014 count  out  CW  number of words inserted since reset/clear, saturating at DEPTH.
REQ-015 full / empty  out  1 each  count == DEPTH / count == 0.
REQ-016 data_out  out  WIDTH*DEPTH  flattened contents, word j at bits [j*WIDTH +: WIDTH].

Function
REQ-017 Accept = in_valid && in_ready && !clr; one accept shifts every word one position in the dir direction and writes in_data to the insert end in the same edge.
REQ-018 Word shifted off the far end SHALL be discarded.
REQ-019 MODE 0: in_ready SHALL be 1 whenever not in reset; MODE 1: in_ready = !full.
REQ-020 count increments by 1 per accept while below DEPTH; at DEPTH it holds.
REQ-021 No accept: contents and count unchanged.
REQ-022 clr asserted: all words and count go to 0 on that edge; clr overrides a concurrent accept and random write.
REQ-023 rd_data SHALL equal the word at rd_addr as it was before the edge (read-old), latency 1 cycle; rd_addr >= DEPTH returns 0.
REQ-024 data_out, count, full, empty SHALL be combinational from registered state (no extra latency).
REQ-025 dir may change every cycle; each accept uses dir sampled at that edge.

Reset
REQ-026 rst asserted: all words, count, rd_data go to 0 immediately; empty = 1, full = 0.
REQ-027 rst mid-sequence discards all state; first accept after release lands at the insert end with count = 1.
REQ-028 in_ready SHALL be 0 while rst is high.

Configuration
REQ-029 Macro IMEM_SHIFT_ARRAY_RAND_WR_EN defined: ports wr_en (1), wr_addr (AW), wr_data (WIDTH) exist; wr_en writes wr_data to word wr_addr without shifting and without changing count.
REQ-030 With the macro, a concurrent accept and random write SHALL apply the shift first, then the write at post-shift index wr_addr (write wins); wr_addr >= DEPTH is ignored.
REQ-031 Macro undefined: the three ports SHALL be absent and no random write logic is built.

Verification
REQ-032 Defaults, dir=0, insert 1..70 (16'h0001..16'h0046) back-to-back -> word 0 = 16'h0046, word 63 = 16'h0007, count = 64, full = 1, in_ready stays 1.
REQ-033 MODE=1, DEPTH=4, 5 inserts A,B,C,D,E -> 5th refused (in_ready = 0), word 0..3 = D,C,B,A.
REQ-034 DEPTH=4, dir=1, insert 1,2,3 -> word 3 = 3, word 2 = 2, word 1 = 1, word 0 = 0, count = 3; rd_addr=2 -> rd_data = 2 one cycle later.
REQ-035 Insert 10 words, clr together with in_valid -> all words 0, count 0, empty = 1; rst pulsed mid-stream between edges -> outputs 0 immediately.
REQ-036 RAND_WR_EN defined, DEPTH=4, contents 4,3,2,1, accept 5 with wr_en, wr_addr=1, wr_data=16'hBEEF -> words 0..3 = 5,BEEF,3,2, count unchanged at saturation.
